piso_serializer: RTL

PISO_SERIALIZER -- requirements
Module: piso_serializer

---
 rtl/piso_pkg.sv | 13 +
 rtl/piso_serializer_fifo.sv | 59 +++++
 rtl/piso_serializer.sv | 120 ++++++++++++
 3 files changed

// File: rtl/piso_pkg.sv
// Shared constants and FSM state encodings for the PISO serializer slice.
package piso_pkg;

    localparam int DATA_W             = 8;
    localparam int DEPTH_FIFO_DEFAULT = 16;

    typedef enum logic [2:0] {
        S_IDLE  = 3'b001,
        S_LOAD  = 3'b010,
        S_SHIFT = 3'b100
    } state_t;

endpackage

// File: rtl/piso_serializer_fifo.sv
// fifo_sync: single-clock byte buffer with synchronous reset and registered read data.
module fifo_sync #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic             sclk_i,
    input  logic             rst_i,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             push;
    logic             pop;

    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);
    assign push  = wr_en && !full;
    assign pop   = rd_en && !empty;

    // Storage has no reset so it can map onto a register array or RAM.
    always_ff @(posedge sclk_i) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge sclk_i) begin
        if (rst_i) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            rd_data <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_data <= mem[rd_ptr];
                rd_ptr  <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/piso_serializer.sv
// Byte-in, bit-out serializer with a byte FIFO and framing flags, LSB first.
// Define PISO_PARITY_EN to append an even-parity bit, giving 9-bit frames.
//
// state   | meaning
// S_IDLE  | waiting for a buffered byte; pops it when the FIFO is non-empty
// S_LOAD  | FIFO read data is valid; load the shift register
// S_SHIFT | driving bits; one bit moves per edge with ready_i high
module piso_serializer
    import piso_pkg::*;
#(
    parameter int DEPTH_FIFO = DEPTH_FIFO_DEFAULT
) (
    input  logic              sclk_i,
    input  logic              rst_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              valid_i,
    output logic              ready_o,
    output logic              data_o,
    output logic              valid_o,
    input  logic              ready_i,
    output logic              sof_o,
    output logic              last_o
);

`ifdef PISO_PARITY_EN
    localparam int FRAME_W = DATA_W + 1;
`else
    localparam int FRAME_W = DATA_W;
`endif
    localparam logic [3:0] LAST_BIT = 4'(FRAME_W - 1);
    localparam logic [3:0] PRE_LAST = 4'(FRAME_W - 2);

    state_t              state;
    logic [FRAME_W-1:0]  shift_reg;
    logic [FRAME_W-1:0]  frame_load;
    logic [3:0]          bit_cnt;
    logic [DATA_W-1:0]   fifo_rd_data;
    logic                fifo_full;
    logic                fifo_empty;
    logic                fifo_wr;
    logic                fifo_rd;
    logic                bit_xfer;
    logic                last_bit;

    assign ready_o  = !rst_i && !fifo_full;
    assign fifo_wr  = valid_i && ready_o;
    assign bit_xfer = (state == S_SHIFT) && ready_i;
    assign last_bit = (bit_cnt == LAST_BIT);
    // Pop early so read data is already registered when S_LOAD samples it.
    assign fifo_rd  = !fifo_empty &&
                      ((state == S_IDLE) || (bit_xfer && last_bit));
    assign data_o   = shift_reg[0];

`ifdef PISO_PARITY_EN
    assign frame_load = {^fifo_rd_data, fifo_rd_data};
`else
    assign frame_load = fifo_rd_data;
`endif

    fifo_sync #(
        .DEPTH (DEPTH_FIFO),
        .WIDTH (DATA_W)
    ) u_fifo (
        .sclk_i  (sclk_i),
        .rst_i   (rst_i),
        .wr_en   (fifo_wr),
        .wr_data (data_i),
        .rd_en   (fifo_rd),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    always_ff @(posedge sclk_i) begin
        if (rst_i) begin
            state     <= S_IDLE;
            shift_reg <= '0;
            bit_cnt   <= '0;
            valid_o   <= 1'b0;
            sof_o     <= 1'b0;
            last_o    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (!fifo_empty) begin
                        state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    shift_reg <= frame_load;
                    bit_cnt   <= '0;
                    valid_o   <= 1'b1;
                    sof_o     <= 1'b1;
                    last_o    <= 1'b0;
                    state     <= S_SHIFT;
                end
                S_SHIFT: begin
                    if (ready_i) begin
                        shift_reg <= shift_reg >> 1;
                        bit_cnt   <= bit_cnt + 4'd1;
                        sof_o     <= 1'b0;
                        last_o    <= (bit_cnt == PRE_LAST);
                        if (last_bit) begin
                            valid_o <= 1'b0;
                            last_o  <= 1'b0;
                            state   <= fifo_empty ? S_IDLE : S_LOAD;
                        end
                    end
                end
                default: begin
                    state   <= S_IDLE;
                    valid_o <= 1'b0;
                    sof_o   <= 1'b0;
                    last_o  <= 1'b0;
                end
            endcase
        end
    end

endmodule
